// File: rtl/halo_receiver_if.sv
// Neighbor-exchange link bundle: per-neighbor halo write ports with clear_to_send,
// plus the single forwarded-write bus toward the accumulator buffer.
interface halo_receiver_if #(
   parameter int TILE_SIZE      = 128,
   parameter int NEIGHBOR_COUNT = 8,
   parameter int DATA_W         = 8
);
   localparam int COORD_W = $clog2(TILE_SIZE);

   logic [NEIGHBOR_COUNT-1:0][DATA_W-1:0]  neighbor_input_value;
   logic [NEIGHBOR_COUNT-1:0][COORD_W-1:0] neighbor_input_row;
   logic [NEIGHBOR_COUNT-1:0][COORD_W-1:0] neighbor_input_column;
   logic [NEIGHBOR_COUNT-1:0]              neighbor_input_write_enable;
   logic [NEIGHBOR_COUNT-1:0]              neighbor_exchange_done;
   logic [NEIGHBOR_COUNT-1:0]              neighbor_cts;

   logic [COORD_W-1:0] acc_row;
   logic [COORD_W-1:0] acc_column;
   logic [DATA_W-1:0]  acc_value;
   logic               acc_write_enable;

   modport master (
      output neighbor_input_value,
      output neighbor_input_row,
      output neighbor_input_column,
      output neighbor_input_write_enable,
      output neighbor_exchange_done,
      input  neighbor_cts,
      input  acc_row,
      input  acc_column,
      input  acc_value,
      input  acc_write_enable
   );

   modport slave (
      input  neighbor_input_value,
      input  neighbor_input_row,
      input  neighbor_input_column,
      input  neighbor_input_write_enable,
      input  neighbor_exchange_done,
      output neighbor_cts,
      output acc_row,
      output acc_column,
      output acc_value,
      output acc_write_enable
   );
endinterface

// File: rtl/halo_receiver.sv
// Receiving end of the PPU neighbor exchange: one FIFO per neighbor link,
// round-robin forwarding of one (row, column, value) write per cycle.
module halo_receiver #(
   parameter int TILE_SIZE      = 128,
   parameter int NEIGHBOR_COUNT = 8,
   parameter int FIFO_DEPTH     = 4,
   parameter int DATA_W         = 8
) (
   input  logic           clk,
   input  logic           reset_n,
   input  logic           start,
   halo_receiver_if.slave link,
   output logic           receive_done,
   output logic           busy,
   output logic           overflow_error
);
   localparam int COORD_W = $clog2(TILE_SIZE);
   localparam int ENTRY_W = DATA_W + 2 * COORD_W;
   localparam int PTR_W   = $clog2(FIFO_DEPTH);
   localparam int CNT_W   = PTR_W + 1;
   localparam int SEL_W   = $clog2(NEIGHBOR_COUNT);
   localparam int SUM_W   = SEL_W + 1;

   localparam logic [CNT_W-1:0] DEPTH_C   = CNT_W'(FIFO_DEPTH);
   localparam logic [CNT_W-1:0] CTS_LIMIT = CNT_W'(FIFO_DEPTH - 2);
   localparam logic [SUM_W-1:0] NB_C      = SUM_W'(NEIGHBOR_COUNT);
   localparam logic [SEL_W-1:0] LAST_NB   = SEL_W'(NEIGHBOR_COUNT - 1);

   typedef enum logic [1:0] {
      S_IDLE    = 2'd0,
      S_RECEIVE = 2'd1,
      S_DRAIN   = 2'd2,
      S_DONE    = 2'd3
   } state_t;

   state_t state, state_nxt;

   logic [ENTRY_W-1:0]                    fifo_mem [NEIGHBOR_COUNT][FIFO_DEPTH];
   logic [NEIGHBOR_COUNT-1:0][PTR_W-1:0]  wr_ptr;
   logic [NEIGHBOR_COUNT-1:0][PTR_W-1:0]  rd_ptr;
   logic [NEIGHBOR_COUNT-1:0][CNT_W-1:0]  count;
   logic [NEIGHBOR_COUNT-1:0][CNT_W-1:0]  count_nxt;
   logic [NEIGHBOR_COUNT-1:0]             done_flags;
   logic [NEIGHBOR_COUNT-1:0]             done_nxt;
   logic [NEIGHBOR_COUNT-1:0]             push;
   logic [NEIGHBOR_COUNT-1:0]             pop;
   logic [NEIGHBOR_COUNT-1:0]             cts_nxt;
   logic [NEIGHBOR_COUNT-1:0]             cts_q;
   logic [SEL_W-1:0]                      rr_ptr;
   logic [SEL_W-1:0]                      grant_idx;
   logic                                  grant_vld;
   logic                                  violation;
   logic                                  all_empty;

   logic [ENTRY_W-1:0]                    acc_entry_p1;
   logic                                  acc_vld_p1;

   // Arbitration: first non-empty FIFO scanning upward from rr_ptr, wrapping.
   always_comb begin
      logic [SUM_W-1:0] cand;
      grant_vld = 1'b0;
      grant_idx = '0;
      cand      = '0;
      if (state == S_RECEIVE || state == S_DRAIN) begin
         for (int k = 0; k < NEIGHBOR_COUNT; k++) begin
            cand = {1'b0, rr_ptr} + SUM_W'(k);
            if (cand >= NB_C) cand = cand - NB_C;
            if (!grant_vld && count[cand[SEL_W-1:0]] != '0) begin
               grant_vld = 1'b1;
               grant_idx = cand[SEL_W-1:0];
            end
         end
      end
   end

   // Push acceptance and occupancy; any write that is not accepted is a violation.
   always_comb begin
      push      = '0;
      pop       = '0;
      count_nxt = count;
      violation = 1'b0;
      all_empty = 1'b1;
      for (int i = 0; i < NEIGHBOR_COUNT; i++) begin
         push[i] = link.neighbor_input_write_enable[i] && (state == S_RECEIVE)
                   && !done_flags[i] && (count[i] != DEPTH_C);
         if (link.neighbor_input_write_enable[i] && !push[i]) violation = 1'b1;
         pop[i]       = grant_vld && (grant_idx == SEL_W'(i));
         count_nxt[i] = count[i] + CNT_W'(push[i]) - CNT_W'(pop[i]);
         if (count[i] != '0) all_empty = 1'b0;
      end
   end

   always_comb begin
      state_nxt = state;
      done_nxt  = done_flags;
      cts_nxt   = '0;
      case (state)
         S_IDLE: begin
            if (start) state_nxt = S_RECEIVE;
         end
         S_RECEIVE: begin
            done_nxt = done_flags | link.neighbor_exchange_done;
            if (&done_flags) state_nxt = S_DRAIN;
         end
         S_DRAIN: begin
            if (all_empty && !grant_vld) state_nxt = S_DONE;
         end
         S_DONE: begin
            done_nxt  = '0;
            state_nxt = S_IDLE;
         end
         default: state_nxt = S_IDLE;
      endcase
      // cts looks at post-edge occupancy, leaving one slot for a write already in flight.
      for (int i = 0; i < NEIGHBOR_COUNT; i++) begin
         cts_nxt[i] = (state_nxt == S_RECEIVE) && !done_nxt[i] && (count_nxt[i] <= CTS_LIMIT);
      end
   end

   always_ff @(posedge clk) begin
      if (!reset_n) state <= S_IDLE;
      else          state <= state_nxt;
   end

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         count          <= '0;
         wr_ptr         <= '0;
         rd_ptr         <= '0;
         done_flags     <= '0;
         rr_ptr         <= '0;
         cts_q          <= '0;
         overflow_error <= 1'b0;
         acc_vld_p1     <= 1'b0;
         acc_entry_p1   <= '0;
      end else begin
         count      <= count_nxt;
         done_flags <= done_nxt;
         cts_q      <= cts_nxt;
         acc_vld_p1 <= grant_vld;
         if (violation) overflow_error <= 1'b1;
         for (int i = 0; i < NEIGHBOR_COUNT; i++) begin
            if (push[i]) wr_ptr[i] <= wr_ptr[i] + PTR_W'(1);
            if (pop[i])  rd_ptr[i] <= rd_ptr[i] + PTR_W'(1);
         end
         // Pop stage -> p1: the granted head becomes the forwarded write next cycle.
         if (grant_vld) begin
            rr_ptr       <= (grant_idx == LAST_NB) ? '0 : grant_idx + SEL_W'(1);
            acc_entry_p1 <= fifo_mem[grant_idx][rd_ptr[grant_idx]];
         end
      end
   end

   always_ff @(posedge clk) begin
      for (int i = 0; i < NEIGHBOR_COUNT; i++) begin
         if (push[i]) begin
            fifo_mem[i][wr_ptr[i]] <= {link.neighbor_input_value[i],
                                       link.neighbor_input_row[i],
                                       link.neighbor_input_column[i]};
         end
      end
   end

   assign link.neighbor_cts     = cts_q;
   assign link.acc_value        = acc_entry_p1[ENTRY_W-1 -: DATA_W];
   assign link.acc_row          = acc_entry_p1[2*COORD_W-1 -: COORD_W];
   assign link.acc_column       = acc_entry_p1[COORD_W-1:0];
   assign link.acc_write_enable = acc_vld_p1;
   assign receive_done          = (state == S_DONE);
   assign busy                  = (state != S_IDLE);
endmodule

// File: tb/tb_halo_receiver.sv
// Directed bench for halo_receiver: a scoreboard queue is filled as neighbors write
// and drained by a monitor as forwarded accumulator writes appear.
module tb_halo_receiver;
   localparam int TILE_SIZE      = 128;
   localparam int NEIGHBOR_COUNT = 8;
   localparam int FIFO_DEPTH     = 4;
   localparam int DATA_W         = 8;

   typedef struct packed {
      logic [6:0] row;
      logic [6:0] col;
      logic [7:0] val;
   } ent_t;

   logic clk = 1'b0;
   logic reset_n = 1'b0;
   logic start = 1'b0;
   logic receive_done, busy, overflow_error;

   int   checks = 0;
   int   failures = 0;
   int   acc_cnt = 0;
   int   rd_cnt = 0;
   bit   loose = 1'b0;
   ent_t exp_q[$];
   ent_t mon_got;
   int   mon_idx;

   int   sent[8];
   int   remaining, guard, acc0;
   bit   dropped, saw_drop;

   halo_receiver_if #(.TILE_SIZE(TILE_SIZE), .NEIGHBOR_COUNT(NEIGHBOR_COUNT), .DATA_W(DATA_W)) link_if ();

   halo_receiver #(
      .TILE_SIZE(TILE_SIZE), .NEIGHBOR_COUNT(NEIGHBOR_COUNT),
      .FIFO_DEPTH(FIFO_DEPTH), .DATA_W(DATA_W)
   ) dut (
      .clk(clk), .reset_n(reset_n), .start(start), .link(link_if),
      .receive_done(receive_done), .busy(busy), .overflow_error(overflow_error)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   task automatic clr_in();
      link_if.neighbor_input_value        = '0;
      link_if.neighbor_input_row          = '0;
      link_if.neighbor_input_column       = '0;
      link_if.neighbor_input_write_enable = '0;
      link_if.neighbor_exchange_done      = '0;
      start = 1'b0;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
      clr_in();
   endtask

   task automatic wr(input int i, input logic [7:0] v, input logic [6:0] r,
                     input logic [6:0] c, input bit expect_out);
      logic [2:0] s;
      ent_t e;
      s = 3'(i);
      link_if.neighbor_input_value[s]        = v;
      link_if.neighbor_input_row[s]          = r;
      link_if.neighbor_input_column[s]       = c;
      link_if.neighbor_input_write_enable[s] = 1'b1;
      e = {r, c, v};
      if (expect_out) exp_q.push_back(e);
   endtask

   task automatic begin_phase();
      start = 1'b1;
      tick();
   endtask

   task automatic do_reset();
      reset_n = 1'b0;
      tick();
      reset_n = 1'b1;
   endtask

   task automatic wait_done(input string tag);
      bit seen;
      int rd0;
      seen = 1'b0;
      rd0  = rd_cnt;
      for (int k = 0; k < 300; k++) begin
         tick();
         if (receive_done === 1'b1) begin
            seen = 1'b1;
            break;
         end
      end
      chk({tag, "_done_seen"}, seen, 1);
      tick();
      chk({tag, "_done_pulses"}, rd_cnt - rd0, 1);
      chk({tag, "_done_low"}, receive_done, 0);
      chk({tag, "_busy_idle"}, busy, 0);
   endtask

   task automatic finish_phase(input string tag);
      link_if.neighbor_exchange_done = '1;
      tick();
      wait_done(tag);
      chk({tag, "_sb_empty"}, exp_q.size(), 0);
   endtask

   // Scoreboard monitor: strict order, or first pending entry for the same row (= neighbor).
   always @(negedge clk) begin
      if (receive_done === 1'b1) rd_cnt++;
      if (link_if.acc_write_enable === 1'b1) begin
         acc_cnt++;
         mon_got = {link_if.acc_row, link_if.acc_column, link_if.acc_value};
         mon_idx = -1;
         if (!loose) begin
            if (exp_q.size() > 0) mon_idx = 0;
         end else begin
            foreach (exp_q[k]) if (mon_idx < 0 && exp_q[k].row == mon_got.row) mon_idx = k;
         end
         chk("acc_write_expected", (mon_idx >= 0), 1);
         if (mon_idx >= 0) begin
            chk("acc_entry", mon_got, exp_q[mon_idx]);
            exp_q.delete(mon_idx);
         end
      end
   end

   initial begin
      clr_in();
      reset_n = 1'b0;
      tick();
      tick();
      chk("rst_cts", link_if.neighbor_cts, 8'h00);
      chk("rst_acc_we", link_if.acc_write_enable, 0);
      chk("rst_acc_value", link_if.acc_value, 0);
      chk("rst_acc_row", link_if.acc_row, 0);
      chk("rst_acc_col", link_if.acc_column, 0);
      chk("rst_busy", busy, 0);
      chk("rst_ovf", overflow_error, 0);
      chk("rst_done", receive_done, 0);
      reset_n = 1'b1;

      // Single entry with 2-edge latency
      begin_phase();
      chk("single_busy", busy, 1);
      chk("single_cts", link_if.neighbor_cts, 8'hFF);
      wr(3, 8'h5A, 7'd7, 7'd9, 1);
      tick();
      chk("single_we_early", link_if.acc_write_enable, 0);
      link_if.neighbor_exchange_done = '1;
      tick();
      chk("single_we", link_if.acc_write_enable, 1);
      chk("single_value", link_if.acc_value, 8'h5A);
      chk("single_row", link_if.acc_row, 7);
      chk("single_col", link_if.acc_column, 9);
      wait_done("single");
      chk("single_sb_empty", exp_q.size(), 0);

      // Round-robin from ptr 0, then from ptr 3
      do_reset();
      loose = 1'b0;
      begin_phase();
      wr(0, 8'hA0, 7'd0, 7'd1, 1);
      wr(2, 8'hA2, 7'd2, 7'd1, 1);
      wr(5, 8'hA5, 7'd5, 7'd1, 1);
      tick();
      for (int k = 0; k < 3; k++) begin
         tick();
         chk("rr1_we", link_if.acc_write_enable, 1);
      end
      tick();
      chk("rr1_we_end", link_if.acc_write_enable, 0);
      wr(2, 8'hB2, 7'd2, 7'd2, 1);
      tick();
      tick();
      tick();
      wr(5, 8'hC5, 7'd5, 7'd3, 1);
      wr(0, 8'hC0, 7'd0, 7'd3, 1);
      wr(2, 8'hC2, 7'd2, 7'd3, 1);
      tick();
      for (int k = 0; k < 3; k++) begin
         tick();
         chk("rr2_we", link_if.acc_write_enable, 1);
      end
      finish_phase("rr");

      // Backpressure: one neighbor at full rate, then all eight streaming
      loose = 1'b1;
      begin_phase();
      dropped = 1'b0;
      for (int k = 0; k < 20; k++) begin
         if (link_if.neighbor_cts[1] !== 1'b1) dropped = 1'b1;
         else wr(1, 8'(8'h10 + k), 7'd1, 7'(k), 1);
         tick();
      end
      chk("bp_single_cts_held", dropped, 0);
      foreach (sent[k]) sent[k] = 0;
      remaining = 80;
      guard = 0;
      saw_drop = 1'b0;
      while (remaining > 0 && guard < 400) begin
         for (int k = 0; k < 8; k++) begin
            if (sent[k] < 10) begin
               if (link_if.neighbor_cts[3'(k)] === 1'b1) begin
                  wr(k, 8'(k * 16 + sent[k]), 7'(k), 7'(sent[k]), 1);
                  sent[k]++;
                  remaining--;
               end else begin
                  saw_drop = 1'b1;
               end
            end
         end
         tick();
         guard++;
      end
      chk("bp_all_sent", remaining, 0);
      chk("bp_cts_dropped", saw_drop, 1);
      chk("bp_no_ovf", overflow_error, 0);
      finish_phase("stream");
      chk("stream_no_ovf", overflow_error, 0);

      // Neighbor 6 sends its last write together with exchange_done, last of all
      loose = 1'b0;
      begin_phase();
      link_if.neighbor_exchange_done = 8'hBF;
      tick();
      wr(6, 8'h66, 7'd6, 7'd6, 1);
      link_if.neighbor_exchange_done[6] = 1'b1;
      tick();
      tick();
      chk("coinc_we", link_if.acc_write_enable, 1);
      chk("coinc_value", link_if.acc_value, 8'h66);
      chk("coinc_cts_drain", link_if.neighbor_cts, 8'h00);
      chk("coinc_busy", busy, 1);
      wait_done("coinc");
      chk("coinc_sb_empty", exp_q.size(), 0);
      chk("coinc_no_ovf", overflow_error, 0);

      // Violation: write while IDLE
      wr(0, 8'h11, 7'd0, 7'd0, 0);
      tick();
      chk("viol_idle_ovf", overflow_error, 1);
      tick();
      chk("viol_idle_no_out", link_if.acc_write_enable, 0);
      do_reset();
      chk("viol_idle_rst_ovf", overflow_error, 0);

      // Violation: write from neighbor 4 after its done flag
      begin_phase();
      link_if.neighbor_exchange_done[4] = 1'b1;
      tick();
      chk("viol_done_pre_ovf", overflow_error, 0);
      wr(4, 8'h44, 7'd4, 7'd4, 0);
      tick();
      chk("viol_done_ovf", overflow_error, 1);
      tick();
      chk("viol_done_no_out", link_if.acc_write_enable, 0);
      finish_phase("viol_done");
      chk("viol_done_ovf_sticky", overflow_error, 1);
      do_reset();

      // Violation: push into a full FIFO (neighbor 7 is last to be granted)
      loose = 1'b1;
      acc0 = acc_cnt;
      begin_phase();
      for (int c = 0; c < 4; c++) begin
         for (int k = 0; k < 8; k++) wr(k, 8'(k * 16 + c), 7'(k), 7'(c), 1);
         tick();
      end
      chk("viol_full_pre_ovf", overflow_error, 0);
      wr(7, 8'hEE, 7'd7, 7'd9, 0);
      tick();
      chk("viol_full_ovf", overflow_error, 1);
      finish_phase("viol_full");
      chk("viol_full_count", acc_cnt - acc0, 32);
      begin_phase();
      chk("viol_next_phase_ovf", overflow_error, 1);
      finish_phase("viol_next");
      chk("viol_after_phase_ovf", overflow_error, 1);
      do_reset();
      chk("viol_rst_ovf", overflow_error, 0);

      // Reset mid-phase with five buffered entries
      loose = 1'b0;
      begin_phase();
      for (int k = 0; k < 5; k++) wr(k, 8'(8'h30 + k), 7'(k), 7'd1, 0);
      tick();
      acc0 = acc_cnt;
      do_reset();
      chk("mid_rst_we", link_if.acc_write_enable, 0);
      chk("mid_rst_value", link_if.acc_value, 0);
      chk("mid_rst_cts", link_if.neighbor_cts, 8'h00);
      chk("mid_rst_busy", busy, 0);
      tick();
      tick();
      chk("mid_rst_no_stale", acc_cnt - acc0, 0);
      begin_phase();
      wr(2, 8'h77, 7'd3, 7'd4, 1);
      tick();
      finish_phase("mid_rst");
      chk("mid_rst_one_write", acc_cnt - acc0, 1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule

// File: doc/halo_receiver.md
Name: halo_receiver

Overview:
- Receiving end of the PPU neighbor-exchange protocol.
- Accepts halo partial sums from up to 8 neighbor PPUs over the neighbor_input_* / neighbor_exchange_done interface and drives clear_to_send back to each neighbor.
- Buffers each neighbor's traffic in a private FIFO, arbitrates round-robin, and emits one (row, column, value) write per cycle toward accumulator_buffer.
- Signals receive_done once every neighbor has finished and all buffered entries are forwarded.

Parameters:
TILE_SIZE, 128, tile dimension; row/column width = $clog2(TILE_SIZE)
NEIGHBOR_COUNT, 8, number of neighbor links
FIFO_DEPTH, 4, entries per neighbor FIFO (power of two, >= 2)

Ports:
clk  in  1  clock, all logic on rising edge
reset_n  in  1  synchronous active-low reset
start  in  1  one-cycle pulse that opens an exchange phase
neighbor_input_value[8]  in  8  halo value from neighbor i
neighbor_input_row[8]  in  $clog2(TILE_SIZE)  target row
neighbor_input_column[8]  in  $clog2(TILE_SIZE)  target column
neighbor_input_write_enable[8]  in  1  neighbor i presents a valid entry this cycle
neighbor_exchange_done[8]  in  1  neighbor i has sent its last entry (level or pulse)
neighbor_cts[8]  out  1  clear_to_send back to neighbor i
acc_row  out  $clog2(TILE_SIZE)  row of forwarded entry
acc_column  out  $clog2(TILE_SIZE)  column of forwarded entry
acc_value  out  8  forwarded value
acc_write_enable  out  1  forwarded entry valid (one cycle per entry)
receive_done  out  1  one-cycle pulse: phase complete
busy  out  1  high in any state other than IDLE
overflow_error  out  1  sticky protocol-violation flag

Behaviour:
- Reset (reset_n low at rising edge): state IDLE; all FIFOs empty; done flags cleared; round-robin pointer = 0; outputs cleared (neighbor_cts all 0, acc_* 0, acc_write_enable 0, receive_done 0, busy 0, overflow_error 0). Reset mid-phase discards all buffered entries.
- State IDLE:
  - neighbor_cts = 0.
  - A write_enable here is dropped and sets overflow_error.
  - start -> RECEIVE.
- State RECEIVE:
  - neighbor_cts[i] registered: 1 iff state is RECEIVE, done flag i is clear, and FIFO i occupancy after this edge <= FIFO_DEPTH-2. Neighbors may issue at most one write after cts falls.
  - write_enable[i] pushes {value,row,column} into FIFO i. Push to a full FIFO is dropped and sets overflow_error.
  - neighbor_exchange_done[i] sets sticky done flag i. A write in the same cycle as done is accepted.
  - Writes from a neighbor whose done flag is already set are dropped and set overflow_error.
  - All 8 done flags set -> DRAIN.
- State DRAIN:
  - neighbor_cts = 0.
  - When all FIFOs are empty and no pop occurs this cycle -> DONE.
- State DONE:
  - receive_done = 1 for exactly one cycle; done flags cleared; -> IDLE.
  - overflow_error remains set until reset.
- start outside IDLE is ignored.
- Arbitration, in RECEIVE and DRAIN:
  - Each cycle, grant the lowest index j, scanning j = ptr, ptr+1, … mod 8, whose FIFO is non-empty. Pop it; ptr <= (j+1) mod 8.
  - With no grant, ptr is unchanged.
- Output registers:
  - The popped entry appears on acc_row/acc_column/acc_value with acc_write_enable=1 the cycle after the pop.
  - Otherwise acc_write_enable=0 and the acc_* data outputs hold their last values.
  - Zero values are forwarded; no filtering or merging.
  - Two entries to the same (row, column) are forwarded separately, in grant order.
- Latency: a write sampled at edge N into an empty FIFO, uncontended, is popped at edge N+1 and is visible on acc_* after edge N+1 (2-edge latency).
- FIFO:
  - Same-cycle push and pop on one FIFO is legal; occupancy is unchanged.
  - Pointers wrap modulo FIFO_DEPTH.
  - Order within one neighbor is preserved.
- busy = (state != IDLE).

Test Plan:
- Single entry: start; neighbor 3 writes value 0x5A, row 7, column 9 at edge N; all done at N+1 -> acc_write_enable at edge N+1 with 0x5A/7/9; receive_done pulses once; busy returns 0.
- Round-robin: neighbors 0, 2, 5 each write one entry in the same cycle -> outputs in order 0, 2, 5 on consecutive cycles. Repeat with ptr at 3 -> order 5, 0, 2.
- Backpressure (FIFO_DEPTH=4): neighbor 1 writes every cycle while cts is honored and all others are idle -> neighbor_cts[1] never drops (drain rate equals fill rate). Then have neighbors 0–7 all stream: each cts drops when occupancy reaches 3 -> no overflow_error; all 8×10 entries forwarded, per-neighbor order intact.
- Protocol violations: write while in IDLE; write to neighbor 4 after its done flag is set; push into a full FIFO -> each entry is dropped, overflow_error=1 and stays 1 through the next phase until reset.
- Done/write coincidence: neighbor 6 asserts its final write and exchange_done in the same cycle, last of all neighbors -> entry forwarded during DRAIN, then receive_done fires.
- Reset mid-phase: 5 entries buffered, reset_n low for one edge -> all outputs 0, FIFOs empty. A new start plus 1 entry yields exactly 1 acc write.
